mem_backdoor_ctrl: RTL and testbench

- Parametrised single-port CPU memory with a built-in backdoor engine for bench and boot use.
- The engine has three operations:
  - LOAD: streams firmware bytes into a memory range.
  - FILL: writes a constant across a range.
  - DUMP: streams a memory range back out.
- It replaces the flat whole-memory override and monitor vectors with valid/ready streams.
- Sits between cpu_top's address/data bus and the system RAM. While an operation is running, it asserts cpu_stall, which feeds the CPU rdy input.

---
 rtl/mem_backdoor_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_mem_backdoor_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_backdoor_ctrl.sv
// Single-port CPU memory with a backdoor engine that loads, fills or dumps an
// address range over valid/ready streams, stalling the CPU while it runs.
module mem_backdoor_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 65536
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_din,
    output logic [DATA_WIDTH-1:0] cpu_dout,
    output logic                  cpu_stall,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [DATA_WIDTH-1:0] fill_data,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  dp_valid,
    output logic [DATA_WIDTH-1:0] dp_data,
    output logic                  dp_last,
    input  logic                  dp_ready,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state
);
    // Handshakes: a beat transfers on a rising edge where valid && ready are both
    // high; a producer holds valid and data stable until that edge.

    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   REM_ONE   = (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_FILL     = 3'd2,
        S_DUMP_RD  = 3'd3,
        S_DUMP_OUT = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   rem;
    logic [DATA_WIDTH-1:0] fill_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [ADDR_WIDTH-1:0] cpu_addr_w;
    logic [ADDR_WIDTH-1:0] ptr_next;
    logic                  cmd_bad;

    function automatic logic [ADDR_WIDTH-1:0] wrap_addr(input logic [ADDR_WIDTH-1:0] a);
        return ADDR_WIDTH'({1'b0, a} % DEPTH_W);
    endfunction

    assign cpu_addr_w = wrap_addr(cpu_addr);
    assign ptr_next   = (ptr == LAST_ADDR) ? '0 : ptr + ADDR_WIDTH'(1);
    assign cmd_bad    = (cmd_len == '0) || (cmd_len > DEPTH_W) || (cmd_op == 2'd3);
    assign dbg_state  = state;

    // One write port shared by the CPU (IDLE) and the LOAD/FILL engine.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cpu_addr_w;
        mem_wdata = cpu_din;
        case (state)
            S_IDLE: mem_we = cpu_we;
            S_LOAD: begin
                mem_we    = ld_valid && ld_ready;
                mem_waddr = ptr;
                mem_wdata = ld_data;
            end
            S_FILL: begin
                mem_we    = 1'b1;
                mem_waddr = ptr;
                mem_wdata = fill_q;
            end
            default: mem_we = 1'b0;
        endcase
        if (reset) mem_we = 1'b0;
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            rem       <= '0;
            fill_q    <= '0;
            cpu_dout  <= '0;
            cpu_stall <= 1'b0;
            cmd_ready <= 1'b1;
            ld_ready  <= 1'b0;
            dp_valid  <= 1'b0;
            dp_data   <= '0;
            dp_last   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!cpu_we) cpu_dout <= mem[cpu_addr_w];
                    if (cmd_valid && cmd_ready) begin
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else begin
                            ptr       <= wrap_addr(cmd_base);
                            rem       <= cmd_len;
                            fill_q    <= fill_data;
                            cpu_stall <= 1'b1;
                            cmd_ready <= 1'b0;
                            case (cmd_op)
                                2'd0: begin
                                    state    <= S_LOAD;
                                    ld_ready <= 1'b1;
                                end
                                2'd1:    state <= S_FILL;
                                default: state <= S_DUMP_RD;
                            endcase
                        end
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        ptr <= ptr_next;
                        rem <= rem - REM_ONE;
                        if (rem == REM_ONE) begin
                            state    <= S_DONE;
                            ld_ready <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    ptr <= ptr_next;
                    rem <= rem - REM_ONE;
                    if (rem == REM_ONE) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DUMP_RD: begin
                    dp_data  <= mem[ptr];
                    dp_valid <= 1'b1;
                    dp_last  <= (rem == REM_ONE);
                    state    <= S_DUMP_OUT;
                end
                S_DUMP_OUT: begin
                    if (dp_ready) begin
                        dp_valid <= 1'b0;
                        dp_last  <= 1'b0;
                        ptr      <= ptr_next;
                        rem      <= rem - REM_ONE;
                        if (rem == REM_ONE) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_DUMP_RD;
                        end
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    cpu_stall <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_backdoor_ctrl.sv
// Directed bench for mem_backdoor_ctrl: CPU access, LOAD, FILL with wrap, DUMP,
// command rejects, CPU writes while busy and reset in the middle of a LOAD.
module tb_mem_backdoor_ctrl;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int DEPTH = 65536;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          cpu_stall;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic [DW-1:0] fill_data;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          dp_valid;
    logic [DW-1:0] dp_data;
    logic          dp_last;
    logic          dp_ready;
    logic          done;
    logic          err;
    logic [2:0]    dbg_state;

    logic [DW-1:0] exp_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    mem_backdoor_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .fill_data(fill_data),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .dp_valid(dp_valid), .dp_data(dp_data), .dp_last(dp_last),
        .dp_ready(dp_ready), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] e);
        logic [DW-1:0] exp_v;
        cpu_we = 1'b0; cpu_addr = a;
        exp_q.push_back(e);
        tick();
        exp_v = exp_q.pop_front();
        check(tag, cpu_dout, exp_v);
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] base,
                            input logic [AW:0] len, input logic [DW-1:0] fd);
        cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len; fill_data = fd;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cpu_dout"}, cpu_dout, 0);
        check({pfx, "_cpu_stall"}, cpu_stall, 0);
        check({pfx, "_cmd_ready"}, cmd_ready, 1);
        check({pfx, "_ld_ready"}, ld_ready, 0);
        check({pfx, "_dp_valid"}, dp_valid, 0);
        check({pfx, "_dp_data"}, dp_data, 0);
        check({pfx, "_dp_last"}, dp_last, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_err"}, err, 0);
        check({pfx, "_state"}, dbg_state, 0);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
    endtask

    initial begin
        logic [DW-1:0] ld_stream [4];
        logic [DW-1:0] exp_v;
        int i, cyc, n, d0, e0;
        logic hs, stall_ok, hold_ok;

        ld_stream = '{8'hA9, 8'h42, 8'h8D, 8'h00};
        reset = 1'b1; cpu_we = 0; cpu_addr = 0; cpu_din = 0;
        cmd_valid = 0; cmd_op = 0; cmd_base = 0; cmd_len = 0; fill_data = 0;
        ld_valid = 0; ld_data = 0; dp_ready = 0;
        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b0;

        // CPU write then read with one-cycle latency
        cpu_write(16'h0010, 8'hA5);
        cpu_write(16'h0011, 8'h3C);
        cpu_read("cpu_rd_11", 16'h0011, 8'h3C);
        cpu_addr = 16'h0010;
        check("cpu_rd_latency_pre", cpu_dout, 8'h3C);
        cpu_read("cpu_rd_10", 16'h0010, 8'hA5);

        // LOAD with random ld_valid
        d0 = done_cnt;
        send_cmd(2'd0, 16'h8000, 17'd4, 8'h00);
        i = 0; cyc = 0; stall_ok = 1'b1;
        while (done !== 1'b1 && cyc < 200) begin
            if (cpu_stall !== 1'b1) stall_ok = 1'b0;
            ld_valid = (i < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            ld_data = ld_valid ? ld_stream[i] : 8'($urandom);
            hs = ld_valid && ld_ready;
            tick();
            if (hs) i++;
            cyc++;
        end
        ld_valid = 1'b0;
        check("load_done", done, 1);
        check("load_beats", i, 4);
        check("load_stall_busy", stall_ok, 1);
        check("load_stall_done", cpu_stall, 1);
        check("load_ld_ready_drop", ld_ready, 0);
        tick();
        check("load_cmd_ready", cmd_ready, 1);
        check("load_stall_idle", cpu_stall, 0);
        check("load_done_once", done_cnt - d0, 1);
        for (int k = 0; k < 4; k++) cpu_read("load_mem", 16'h8000 + 16'(k), ld_stream[k]);

        // FILL across the top of memory
        cpu_write(16'h0002, 8'h12);
        send_cmd(2'd1, 16'hFFFE, 17'd4, 8'hEA);
        wait_done(cyc);
        check("fill_cycles", cyc, 4);
        tick();
        cpu_read("fill_fffe", 16'hFFFE, 8'hEA);
        cpu_read("fill_ffff", 16'hFFFF, 8'hEA);
        cpu_read("fill_0000", 16'h0000, 8'hEA);
        cpu_read("fill_0001", 16'h0001, 8'hEA);
        cpu_read("fill_0002_kept", 16'h0002, 8'h12);

        // DUMP of the same range with random dp_ready
        d0 = done_cnt;
        for (int k = 0; k < 4; k++) exp_q.push_back(8'hEA);
        send_cmd(2'd2, 16'hFFFE, 17'd4, 8'h00);
        n = 0; cyc = 0; hold_ok = 1'b1;
        while (done !== 1'b1 && cyc < 200) begin
            dp_ready = 1'($urandom_range(0, 1));
            hs = dp_valid && dp_ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("dump_extra_word", 1, 0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("dump_data", dp_data, exp_v);
                    check("dump_last", dp_last, (n == 3));
                end
                n++;
            end
            tick();
            if (!hs && cyc > 0 && dp_valid !== 1'b1 && done !== 1'b1 && n > 0 && dut.dbg_state == 3'd4)
                hold_ok = 1'b0;
            cyc++;
        end
        dp_ready = 1'b0;
        check("dump_done", done, 1);
        check("dump_words", n, 4);
        check("dump_queue_empty", exp_q.size(), 0);
        tick();
        check("dump_done_once", done_cnt - d0, 1);

        // Rejected commands
        cpu_write(16'h0030, 8'h5A);
        d0 = done_cnt; e0 = err_cnt;
        send_cmd(2'd1, 16'h0030, 17'd0, 8'h99);
        check("rej_len0_err", err, 1);
        check("rej_len0_cmd_ready", cmd_ready, 1);
        check("rej_len0_stall", cpu_stall, 0);
        send_cmd(2'd1, 16'h0030, 17'd65537, 8'h99);
        check("rej_long_err", err, 1);
        check("rej_long_cmd_ready", cmd_ready, 1);
        send_cmd(2'd3, 16'h0030, 17'd4, 8'h99);
        check("rej_op3_err", err, 1);
        check("rej_op3_cmd_ready", cmd_ready, 1);
        tick();
        check("rej_err_cleared", err, 0);
        check("rej_err_count", err_cnt - e0, 3);
        check("rej_no_done", done_cnt - d0, 0);
        cpu_read("rej_mem_kept", 16'h0030, 8'h5A);

        // CPU write while a FILL is busy must be dropped
        cpu_write(16'h0020, 8'h11);
        cpu_read("busy_pre", 16'h0011, 8'h3C);
        send_cmd(2'd1, 16'h0100, 17'd8, 8'h77);
        cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_din = 8'h55;
        wait_done(cyc);
        cpu_we = 1'b0;
        check("busy_fill_cycles", cyc, 8);
        check("busy_dout_held", cpu_dout, 8'h3C);
        tick();
        cpu_read("busy_mem_20", 16'h0020, 8'h11);
        cpu_read("busy_fill_107", 16'h0107, 8'h77);

        // Reset in the middle of a LOAD
        for (int k = 0; k < 4; k++) cpu_write(16'h9000 + 16'(k), 8'hFF);
        d0 = done_cnt;
        send_cmd(2'd0, 16'h9000, 17'd8, 8'h00);
        ld_valid = 1'b1; ld_data = 8'h10;
        tick();
        ld_data = 8'h11;
        tick();
        ld_data = 8'h12; reset = 1'b1;
        tick();
        reset = 1'b0; ld_valid = 1'b0;
        check_reset_outputs("mid_rst");
        repeat (3) tick();
        check("mid_rst_no_done", done_cnt - d0, 0);
        cpu_read("mid_rst_9000", 16'h9000, 8'h10);
        cpu_read("mid_rst_9001", 16'h9001, 8'h11);
        cpu_read("mid_rst_9002", 16'h9002, 8'hFF);
        cpu_read("mid_rst_9003", 16'h9003, 8'hFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
